// File: rtl/am_env_scheduler_if.sv
// Control/config bus of the AM envelope scheduler. The master side drives
// start/stop commands, config writes and the NCO wrap pulse; the slave side
// (the scheduler) returns the applied step/depth and status.
interface am_env_scheduler_if;
    logic        i_start;
    logic        i_stop;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [31:0] i_cfg_step;
    logic [15:0] i_cfg_depth_q15;
    logic        i_wrap;
    logic        o_nco_enable;
    logic [31:0] o_am_step;
    logic [15:0] o_depth_q15;
    logic [1:0]  o_state;
    logic        o_busy;

    modport master (
        output i_start, i_stop, i_cfg_valid, i_cfg_step, i_cfg_depth_q15, i_wrap,
        input  o_cfg_ready, o_nco_enable, o_am_step, o_depth_q15, o_state, o_busy
    );

    modport slave (
        input  i_start, i_stop, i_cfg_valid, i_cfg_step, i_cfg_depth_q15, i_wrap,
        output o_cfg_ready, o_nco_enable, o_am_step, o_depth_q15, o_state, o_busy
    );
endinterface

// File: rtl/am_env_scheduler.sv
// AM envelope scheduler: sequences fade-in / run / fade-out of the AM depth,
// ramping at most RAMP_INC per envelope period (one i_wrap), and applies
// step/depth config writes glitch-free at envelope wrap boundaries.
module am_env_scheduler #(
    parameter logic [31:0] DEFAULT_STEP = 32'd85899,
    parameter logic [15:0] RAMP_INC     = 16'd1024
) (
    input  logic            clk,
    input  logic            rst,
    am_env_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        RUN      = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    localparam logic [15:0] DEPTH_MAX = 16'h7FFF;

    state_t      state, state_n;
    logic [15:0] depth, depth_n;
    logic [15:0] target, target_n;
    logic [31:0] am_step, am_step_n;
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_step, pend_step_n;
    logic [15:0] pend_depth, pend_depth_n;
    logic        cfg_ready, cfg_ready_n;
    logic        nco_en, nco_en_n;
    logic        busy, busy_n;

    logic        accept;
    logic        wrap_en;
    logic        start_cmd;
    logic        stop_cmd;
    logic [15:0] cfg_depth_sat;
    logic [15:0] sel_target;
    logic [16:0] depth_x, tgt_x, ramp_x, diff_up, diff_dn, toward_x, fade_down_x;

    // Request decode; stop wins over a coincident start.
    assign accept        = bus.i_cfg_valid && cfg_ready;
    assign wrap_en       = bus.i_wrap && nco_en;
    assign stop_cmd      = bus.i_stop;
    assign start_cmd     = bus.i_start && !bus.i_stop;
    assign cfg_depth_sat = bus.i_cfg_depth_q15[15] ? DEPTH_MAX : bus.i_cfg_depth_q15;

    // A full shadow supplies the target for this wrap before the depth step.
    assign sel_target  = pend_valid ? pend_depth : target;

    // Ramp arithmetic in 17 bits so depth +/- RAMP_INC can never wrap.
    assign depth_x     = {1'b0, depth};
    assign tgt_x       = {1'b0, sel_target};
    assign ramp_x      = {1'b0, RAMP_INC};
    assign diff_up     = tgt_x - depth_x;
    assign diff_dn     = depth_x - tgt_x;
    assign toward_x    = (tgt_x > depth_x)
                         ? depth_x + ((diff_up > ramp_x) ? ramp_x : diff_up)
                         : depth_x - ((diff_dn > ramp_x) ? ramp_x : diff_dn);
    assign fade_down_x = depth_x - ((depth_x > ramp_x) ? ramp_x : depth_x);

    // Next-state, depth ramp and config/shadow handling.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_n      = state;
        depth_n      = depth;
        target_n     = target;
        am_step_n    = am_step;
        pend_valid_n = pend_valid;
        pend_step_n  = pend_step;
        pend_depth_n = pend_depth;

        if (state == IDLE) begin
            // A write that landed in the shadow on the way into IDLE is applied now.
            if (pend_valid) begin
                am_step_n    = pend_step;
                target_n     = pend_depth;
                pend_valid_n = 1'b0;
            end
            if (accept) begin
                am_step_n = bus.i_cfg_step;
                target_n  = cfg_depth_sat;
            end
            if (start_cmd) begin
                state_n = FADE_IN;
                depth_n = 16'd0;
            end
        end else begin
            // Envelope boundary: pick up the shadow, then step the depth.
            if (wrap_en) begin
                target_n = sel_target;
                if (pend_valid) begin
                    am_step_n    = pend_step;
                    pend_valid_n = 1'b0;
                end
                case (state)
                    FADE_IN: begin
                        depth_n = toward_x[15:0];
                        if (toward_x == tgt_x) state_n = RUN;
                    end
                    RUN: depth_n = toward_x[15:0];
                    FADE_OUT: begin
                        if (depth == 16'd0) state_n = IDLE;
                        else                depth_n = fade_down_x[15:0];
                    end
                    default: ;
                endcase
            end
            // A write accepted alongside a wrap waits for the next wrap.
            if (accept) begin
                pend_valid_n = 1'b1;
                pend_step_n  = bus.i_cfg_step;
                pend_depth_n = cfg_depth_sat;
            end
            // Commands take effect after this cycle's depth step.
            if (stop_cmd && state != FADE_OUT) begin
                state_n = FADE_OUT;
            end else if (start_cmd && state == FADE_OUT) begin
                state_n = FADE_IN;
            end
        end

        cfg_ready_n = (state_n == IDLE) || !pend_valid_n;
        nco_en_n    = (state_n != IDLE);
        busy_n      = (state_n != IDLE);
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            depth      <= 16'd0;
            target     <= 16'd0;
            am_step    <= DEFAULT_STEP;
            pend_valid <= 1'b0;
            pend_step  <= 32'd0;
            pend_depth <= 16'd0;
            cfg_ready  <= 1'b1;
            nco_en     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            depth      <= depth_n;
            target     <= target_n;
            am_step    <= am_step_n;
            pend_valid <= pend_valid_n;
            pend_step  <= pend_step_n;
            pend_depth <= pend_depth_n;
            cfg_ready  <= cfg_ready_n;
            nco_en     <= nco_en_n;
            busy       <= busy_n;
        end
    end

    assign bus.o_state      = state;
    assign bus.o_depth_q15  = depth;
    assign bus.o_am_step    = am_step;
    assign bus.o_cfg_ready  = cfg_ready;
    assign bus.o_nco_enable = nco_en;
    assign bus.o_busy       = busy;

endmodule

// File: tb/tb_am_env_scheduler.sv
// Bench for am_env_scheduler: each driven stimulus cycle pushes the expected
// output snapshot into a scoreboard queue, popped and compared after the edge.
module tb_am_env_scheduler;

    localparam logic [31:0] DEF_STEP = 32'd85899;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        en;
        logic [15:0] depth;
        logic [31:0] step;
        logic        ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    am_env_scheduler_if bus ();

    am_env_scheduler #(
        .DEFAULT_STEP (32'd85899),
        .RAMP_INC     (16'd1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st, input logic en,
                            input logic [15:0] depth, input logic [31:0] step, input logic ready);
        exp_t e;
        e.tag = tag; e.st = st; e.en = en; e.depth = depth; e.step = step; e.ready = ready;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".state"}, 32'(bus.o_state),      32'(e.st));
            check({e.tag, ".en"},    32'(bus.o_nco_enable), 32'(e.en));
            check({e.tag, ".busy"},  32'(bus.o_busy),       32'(e.st != 2'd0));
            check({e.tag, ".depth"}, 32'(bus.o_depth_q15),  32'(e.depth));
            check({e.tag, ".step"},  bus.o_am_step,         e.step);
            check({e.tag, ".ready"}, 32'(bus.o_cfg_ready),  32'(e.ready));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One stimulus cycle: apply inputs, clock once, release, compare.
    task automatic drive(input logic valid, input logic [31:0] step, input logic [15:0] depth,
                         input logic start, input logic stop, input logic wrap);
        bus.i_cfg_valid     = valid;
        bus.i_cfg_step      = step;
        bus.i_cfg_depth_q15 = depth;
        bus.i_start         = start;
        bus.i_stop          = stop;
        bus.i_wrap          = wrap;
        tick();
        bus.i_cfg_valid = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_wrap      = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_cfg_valid = 1'b0;
        bus.i_cfg_step = 32'd0; bus.i_cfg_depth_q15 = 16'd0; bus.i_wrap = 1'b0;
        tick(); tick();
        push_exp("reset", 2'd0, 1'b0, 16'd0, DEF_STEP, 1'b1);
        drain();
        rst = 1'b0;

        // IDLE write applies directly; depth stays 0.
        push_exp("idle_wr", 2'd0, 1'b0, 16'd0, 32'd171798, 1'b1);
        drive(1'b1, 32'd171798, 16'd4096, 1'b0, 1'b0, 1'b0);
        push_exp("idle_wr2", 2'd0, 1'b0, 16'd0, 32'd171798, 1'b1);
        drive(1'b1, 32'd171798, 16'd3000, 1'b0, 1'b0, 1'b0);
        push_exp("idle_wrap_ign", 2'd0, 1'b0, 16'd0, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Fade in to 3000.
        push_exp("start", 2'd1, 1'b1, 16'd0, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        push_exp("fi_w1", 2'd1, 1'b1, 16'd1024, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("fi_w2", 2'd1, 1'b1, 16'd2048, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("fi_w3", 2'd2, 1'b1, 16'd3000, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Fade out to IDLE.
        push_exp("stop", 2'd3, 1'b1, 16'd3000, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        push_exp("fo_w1", 2'd3, 1'b1, 16'd1976, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("fo_w2", 2'd3, 1'b1, 16'd952, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("fo_w3", 2'd3, 1'b1, 16'd0, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("fo_w4", 2'd0, 1'b0, 16'd0, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Back to RUN at 3000, then a shadowed write with saturation.
        push_exp("start2", 2'd1, 1'b1, 16'd0, 32'd171798, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_exp("fi2", (i == 2) ? 2'd2 : 2'd1, 1'b1, (i == 2) ? 16'd3000 : 16'(1024 * (i + 1)),
                     32'd171798, 1'b1);
            drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        end
        push_exp("run_wr", 2'd2, 1'b1, 16'd3000, 32'd171798, 1'b0);
        drive(1'b1, 32'd42950, 16'd40000, 1'b0, 1'b0, 1'b0);
        push_exp("stall1", 2'd2, 1'b1, 16'd3000, 32'd171798, 1'b0);
        drive(1'b1, 32'd1, 16'd5, 1'b0, 1'b0, 1'b0);
        push_exp("stall2", 2'd2, 1'b1, 16'd3000, 32'd171798, 1'b0);
        drive(1'b1, 32'd1, 16'd5, 1'b0, 1'b0, 1'b0);
        push_exp("shadow_apply", 2'd2, 1'b1, 16'd4024, 32'd42950, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("sat_target", 2'd2, 1'b1, 16'd5048, 32'd42950, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Write coinciding with a wrap lands at the following wrap.
        push_exp("wr_at_wrap", 2'd2, 1'b1, 16'd6072, 32'd42950, 1'b0);
        drive(1'b1, 32'd100000, 16'd5500, 1'b0, 1'b0, 1'b1);
        push_exp("next_wrap", 2'd2, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        // start+stop together in RUN: stop wins.
        push_exp("start_stop", 2'd3, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        push_exp("fo_restart", 2'd1, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        push_exp("fi_at_tgt", 2'd2, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("stop3", 2'd3, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        push_exp("start3", 2'd1, 1'b1, 16'd5500, 32'd100000, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        push_exp("fi_pend", 2'd1, 1'b1, 16'd5500, 32'd100000, 1'b0);
        drive(1'b1, 32'd7, 16'd100, 1'b0, 1'b0, 1'b0);

        // Reset mid fade-in, alongside a wrap: reset values, no step.
        rst = 1'b1;
        push_exp("rst_mid", 2'd0, 1'b0, 16'd0, DEF_STEP, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // Target 0: first wrap takes FADE_IN -> RUN, then out to IDLE.
        push_exp("z_start", 2'd1, 1'b1, 16'd0, DEF_STEP, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        push_exp("z_wrap", 2'd2, 1'b1, 16'd0, DEF_STEP, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        push_exp("z_stop", 2'd3, 1'b1, 16'd0, DEF_STEP, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        push_exp("z_idle", 2'd0, 1'b0, 16'd0, DEF_STEP, 1'b1);
        drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am_env_scheduler.md
AM_ENV_SCHEDULER -- requirements
Module: am_env_scheduler

Interface
REQ-001 SHALL have parameter DEFAULT_STEP, default 32'd85899: AM step after reset (~1 kHz at 50 MHz).
REQ-002 SHALL have parameter RAMP_INC, default 16'd1024: maximum Q1.15 depth change per envelope period.
REQ-003 SHALL have port clk  in  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  in  1  single-cycle request to begin AM.
REQ-006 SHALL have port i_stop  in  1  single-cycle request to fade out and end AM.
REQ-007 SHALL have port i_cfg_valid  in  1  config write valid.
REQ-008 SHALL have port o_cfg_ready  out  1  config write ready.
REQ-009 SHALL have port i_cfg_step  in  32  requested envelope NCO phase increment.
REQ-010 SHALL have port i_cfg_depth_q15  in  16  requested target depth (Q1.15).
REQ-011 SHALL have port i_wrap  in  1  one-cycle pulse from the envelope NCO at phase-accumulator wrap.
REQ-012 SHALL have port o_nco_enable  out  1  envelope NCO enable.
REQ-013 SHALL have port o_am_step  out  32  applied NCO step.
REQ-014 SHALL have port o_depth_q15  out  16  applied depth (0..32767).
REQ-015 SHALL have port o_state  out  2  0=IDLE, 1=FADE_IN, 2=RUN, 3=FADE_OUT.
REQ-016 SHALL have port o_busy  out  1  high when state is not IDLE.

Function
REQ-017 SHALL register every output; each output changes only on the clock edge that follows the triggering input.
REQ-018 SHALL accept a config write on a cycle where i_cfg_valid and o_cfg_ready are both high.
REQ-019 SHALL saturate any accepted depth above 32767 to 32767.
REQ-020 SHALL, in IDLE, hold o_cfg_ready=1 and apply an accepted write directly: o_am_step and target depth update on the next cycle.
REQ-021 SHALL, in IDLE, hold o_depth_q15=0 and o_nco_enable=0.
REQ-022 SHALL, outside IDLE, latch an accepted write into a one-entry pending shadow.
REQ-023 SHALL drive o_cfg_ready=0 while the pending shadow is full.
REQ-024 SHALL transfer the pending shadow into o_am_step and the target depth on the next i_wrap, then clear the shadow.
REQ-025 SHALL place a write accepted in the same cycle as an i_wrap into the shadow, to be applied at the following i_wrap.
REQ-026 SHALL, on each i_wrap, first select the new target (the pending target if the shadow is full, otherwise the current target), then step the depth toward it.
REQ-027 SHALL limit each depth step to RAMP_INC and never overshoot the target; ramp arithmetic SHALL use 17 bits to avoid overflow.
REQ-028 SHALL ignore i_wrap whenever o_nco_enable=0.
REQ-029 SHALL move IDLE -> FADE_IN on i_start; o_nco_enable=1 from the next cycle, with depth starting at 0.
REQ-030 SHALL, in FADE_IN, raise the depth on each i_wrap by min(RAMP_INC, target-depth), and move to RUN on the i_wrap where depth reaches target.
REQ-031 SHALL move IDLE -> FADE_IN -> RUN on the first i_wrap when the target is 0.
REQ-032 SHALL, in RUN, move the depth on each i_wrap toward the target by at most RAMP_INC, in either direction.
REQ-033 SHALL move FADE_IN or RUN -> FADE_OUT on i_stop.
REQ-034 SHALL, in FADE_OUT, lower the depth on each i_wrap by min(RAMP_INC, depth).
REQ-035 SHALL, in FADE_OUT, move to IDLE on the i_wrap where the depth is already 0, with o_nco_enable=0 on the next cycle.
REQ-036 SHALL move FADE_OUT -> FADE_IN on i_start, keeping the current depth.
REQ-037 SHALL give i_stop priority over i_start when both are asserted.
REQ-038 SHALL ignore i_start in FADE_IN/RUN and i_stop in IDLE/FADE_OUT.
REQ-039 SHALL, when i_start/i_stop coincide with i_wrap, apply the depth step of the current state, then take the transition.

Reset
REQ-040 SHALL, on rst, set state=IDLE, o_nco_enable=0, o_depth_q15=0, o_am_step=DEFAULT_STEP, target=0, shadow empty, o_cfg_ready=1, o_busy=0.
REQ-041 SHALL give rst priority over all other inputs.
REQ-042 SHALL, on rst mid-fade, reach the reset values on the next cycle with no further depth steps.

Verification
REQ-043 Bench SHALL cover: reset, then IDLE write step=171798, depth=4096 -> next cycle o_am_step=171798; o_depth_q15 stays 0; o_cfg_ready stays 1.
REQ-044 Bench SHALL cover: target=3000, RAMP_INC=1024, i_start, then 3 wraps -> depth 1024, 2048, 3000; state=RUN after the third wrap.
REQ-045 Bench SHALL cover: RUN at depth 3000, i_stop, 4 wraps -> depth 1976, 952, 0, then IDLE with o_nco_enable=0 one cycle after the 4th wrap.
REQ-046 Bench SHALL cover: in RUN, write step=42950, depth=40000 -> o_cfg_ready=0; o_am_step unchanged until the next wrap; target saturates to 32767; a second write is stalled until then.
REQ-047 Bench SHALL cover: cfg accept and i_wrap in the same cycle -> the write applies at the following wrap, not the current one.
REQ-048 Bench SHALL cover: i_start and i_stop together in RUN -> FADE_OUT; rst asserted mid FADE_IN -> all outputs at reset values on the next cycle.
